// File: rtl/interleaver_pkg.sv
// Shared constants and FSM state type for the row/column block interleaver pair.
package interleaver_pkg;

    localparam int DEF_ROWS   = 12;
    localparam int DEF_COLS   = 8;
    localparam int ROW_CODE_W = 4;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } ilv_state_e;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/interleaver_addr_ctr.sv
// Two-level wrap-around counter: lo advances every enabled cycle, hi advances when lo wraps.
module interleaver_addr_ctr
    import interleaver_pkg::*;
#(
    parameter int HI_N = DEF_ROWS,
    parameter int LO_N = DEF_COLS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    clr_i,
    output logic [cnt_w(HI_N)-1:0]  hi_o,
    output logic [cnt_w(LO_N)-1:0]  lo_o,
    output logic                    wrap_o
);

    localparam int HW = cnt_w(HI_N);
    localparam int LW = cnt_w(LO_N);
    localparam logic [HW-1:0] HI_MAX = HW'(HI_N - 1);
    localparam logic [LW-1:0] LO_MAX = LW'(LO_N - 1);

    logic [HW-1:0] hi_q, hi_d;
    logic [LW-1:0] lo_q, lo_d;

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        wrap_o = en_i && (hi_q == HI_MAX) && (lo_q == LO_MAX);
        if (clr_i) begin
            hi_d = '0;
            lo_d = '0;
        end else if (en_i) begin
            if (lo_q == LO_MAX) begin
                lo_d = '0;
                hi_d = (hi_q == HI_MAX) ? '0 : hi_q + 1'b1;
            end else begin
                lo_d = lo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/block_interleaver_tx.sv
// Row-major fill / column-major drain block interleaver with 1-based row codes.
// Optional frame-end flag dout_last is built when INTERLEAVER_LAST_EN is defined.
module block_interleaver_tx
    import interleaver_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [ROW_CODE_W-1:0] dout_row
`ifdef INTERLEAVER_LAST_EN
    ,
    output logic                  dout_last
`endif
);

    localparam int RW = cnt_w(ROWS);
    localparam int CW = cnt_w(COLS);

    ilv_state_e state_q, state_d;

    logic [ROWS-1:0][COLS-1:0] mem_q;

    logic [RW-1:0] wr_row, rd_row;
    logic [CW-1:0] wr_col, rd_col;
    logic          wr_en, rd_en, wr_wrap, rd_wrap, rd_end;

    assign wr_en = (state_q == FILL) && din_valid;
    assign rd_en = (state_q == DRAIN) && dout_ready;

    // Write walks columns fastest, read walks rows fastest, so the read
    // counter is the same block with the two moduli swapped.
    interleaver_addr_ctr #(.HI_N(ROWS), .LO_N(COLS)) u_wr_ctr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (wr_en),
        .clr_i  (state_q == DRAIN),
        .hi_o   (wr_row),
        .lo_o   (wr_col),
        .wrap_o (wr_wrap)
    );

    interleaver_addr_ctr #(.HI_N(COLS), .LO_N(ROWS)) u_rd_ctr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (rd_en),
        .clr_i  (state_q == FILL),
        .hi_o   (rd_col),
        .lo_o   (rd_row),
        .wrap_o (rd_wrap)
    );

    assign rd_end = (rd_row == RW'(ROWS - 1)) && (rd_col == CW'(COLS - 1));

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_row][wr_col] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        dout       = 1'b0;
        dout_row   = '0;
`ifdef INTERLEAVER_LAST_EN
        dout_last  = 1'b0;
`endif
        case (state_q)
            FILL: begin
                din_ready = 1'b1;
                if (wr_wrap) state_d = DRAIN;
            end
            DRAIN: begin
                dout_valid = 1'b1;
                dout       = mem_q[rd_row][rd_col];
                dout_row   = ROW_CODE_W'(rd_row) + ROW_CODE_W'(1);
`ifdef INTERLEAVER_LAST_EN
                dout_last  = rd_end;
`endif
                if (rd_wrap) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

`ifndef INTERLEAVER_LAST_EN
    logic unused_rd_end;
    assign unused_rd_end = rd_end;
`endif

endmodule

// File: tb/tb_block_interleaver_tx.sv
// Directed bench: 12x8 instance for the main scenarios, 15x2 instance for the parameter corner.
module tb_block_interleaver_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       din, din_valid, din_ready, dout, dout_valid, dout_ready;
    logic [3:0] dout_row;
    logic       c_din, c_dv, c_din_ready, c_dout, c_dout_valid, c_dr;
    logic [3:0] c_row;
`ifdef INTERLEAVER_LAST_EN
    logic dout_last, c_last;
`endif

    block_interleaver_tx #(.ROWS(12), .COLS(8)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_row(dout_row)
`ifdef INTERLEAVER_LAST_EN
        , .dout_last(dout_last)
`endif
    );

    block_interleaver_tx #(.ROWS(15), .COLS(2)) u_corner (
        .clk(clk), .rst(rst), .din(c_din), .din_valid(c_dv), .din_ready(c_din_ready),
        .dout(c_dout), .dout_valid(c_dout_valid), .dout_ready(c_dr), .dout_row(c_row)
`ifdef INTERLEAVER_LAST_EN
        , .dout_last(c_last)
`endif
    );

    int total  = 0;
    int passed = 0;

    bit       cap_d [96];
    bit [3:0] cap_r [96];
    bit       cap_l [96];
    bit       st_d  [5];
    bit [3:0] st_r  [5];
    int       fill_vld, drain_drop;
    bit       to_flag;

    function automatic bit pat(input int k, input bit inv);
        return ((k % 3) == 0) ^ inv;
    endfunction

    function automatic bit expo(input int j, input int r, input int c, input bit inv);
        return pat((j % r) * c + j / r, inv);
    endfunction

    // Stimulus only: entered and left on a falling edge.
    task automatic do_fill(input int n, input bit inv, input bit rnd);
        int k = 0;
        int cyc = 0;
        fill_vld = 0;
        to_flag  = 0;
        while (k < n) begin
            if (cyc > 2000) begin to_flag = 1; break; end
            din_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            din       = pat(k, inv);
            if (dout_valid) fill_vld++;
            if (din_valid && din_ready) k++;
            cyc++;
            @(negedge clk);
        end
        din_valid = 1'b0;
        din       = 1'b0;
    endtask

    task automatic do_drain(input int n, input int stall_at, input bit junk);
        int j = 0;
        int s = 0;
        int cyc = 0;
        drain_drop = 0;
        to_flag    = 0;
        while (j < n) begin
            if (cyc > 2000) begin to_flag = 1; break; end
            din_valid = junk;
            din       = junk & cyc[0];
            if (!dout_valid) begin
                drain_drop++;
                dout_ready = 1'b1;
            end else if (j == stall_at && s < 5) begin
                dout_ready = 1'b0;
                st_d[s] = dout;
                st_r[s] = dout_row;
                s++;
            end else begin
                dout_ready = 1'b1;
                cap_d[j] = dout;
                cap_r[j] = dout_row;
`ifdef INTERLEAVER_LAST_EN
                cap_l[j] = dout_last;
`else
                cap_l[j] = 1'b0;
`endif
                j++;
            end
            cyc++;
            @(negedge clk);
        end
        din_valid  = 1'b0;
        din        = 1'b0;
        dout_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; din = 0; din_valid = 0; dout_ready = 1;
        c_din = 0; c_dv = 0; c_dr = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (din_ready !== 1'b1) $display("FAIL reset_din_ready got %b want 1", din_ready); else passed++;
        total++; if (dout_valid !== 1'b0) $display("FAIL reset_dout_valid got %b want 0", dout_valid); else passed++;
        total++; if (dout !== 1'b0) $display("FAIL reset_dout got %b want 0", dout); else passed++;
        total++; if (dout_row !== 4'd0) $display("FAIL reset_dout_row got %0d want 0", dout_row); else passed++;
`ifdef INTERLEAVER_LAST_EN
        total++; if (dout_last !== 1'b0) $display("FAIL reset_dout_last got %b want 0", dout_last); else passed++;
`endif
    endtask

    task automatic test_ramp;
        do_fill(96, 0, 0);
        total++; if (to_flag) $display("FAIL ramp_fill_timeout got 1 want 0"); else passed++;
        total++; if (fill_vld !== 0) $display("FAIL ramp_early_valid got %0d want 0", fill_vld); else passed++;
        total++; if (dout_valid !== 1'b1) $display("FAIL ramp_first_valid got %b want 1", dout_valid); else passed++;
        total++; if (din_ready !== 1'b0) $display("FAIL ramp_drain_ready got %b want 0", din_ready); else passed++;
        total++; if (dout_row !== 4'd1) $display("FAIL ramp_first_row got %0d want 1", dout_row); else passed++;
        do_drain(96, -1, 0);
        total++; if (to_flag || drain_drop != 0) $display("FAIL ramp_drain_flow got drop=%0d to=%b want 0/0", drain_drop, to_flag); else passed++;
        total++; if (cap_d[0] !== 1'b1) $display("FAIL ramp_out0 got %b want 1", cap_d[0]); else passed++;
        total++; if (cap_d[1] !== 1'b0) $display("FAIL ramp_out1 got %b want 0", cap_d[1]); else passed++;
        total++; if (cap_d[12] !== 1'b0) $display("FAIL ramp_out12 got %b want 0", cap_d[12]); else passed++;
        for (int j = 0; j < 96; j++) begin
            total++; if (cap_d[j] !== expo(j, 12, 8, 0)) $display("FAIL ramp_data j=%0d got %b want %b", j, cap_d[j], expo(j, 12, 8, 0)); else passed++;
            total++; if (cap_r[j] !== 4'((j % 12) + 1)) $display("FAIL ramp_row j=%0d got %0d want %0d", j, cap_r[j], (j % 12) + 1); else passed++;
`ifdef INTERLEAVER_LAST_EN
            total++; if (cap_l[j] !== (j == 95)) $display("FAIL last_flag j=%0d got %b want %b", j, cap_l[j], (j == 95)); else passed++;
`endif
        end
        total++; if (din_ready !== 1'b1) $display("FAIL ramp_refill_ready got %b want 1", din_ready); else passed++;
        total++; if (dout_valid !== 1'b0) $display("FAIL ramp_end_valid got %b want 0", dout_valid); else passed++;
        total++; if (dout_row !== 4'd0) $display("FAIL ramp_end_row got %0d want 0", dout_row); else passed++;
    endtask

    task automatic test_stalls;
        do_fill(96, 0, 1);
        total++; if (to_flag || fill_vld != 0) $display("FAIL stall_fill got to=%b vld=%0d want 0/0", to_flag, fill_vld); else passed++;
        do_drain(96, 13, 0);
        total++; if (to_flag) $display("FAIL stall_drain_timeout got 1 want 0"); else passed++;
        for (int s = 0; s < 5; s++) begin
            total++; if (st_r[s] !== 4'd2) $display("FAIL stall_row s=%0d got %0d want 2", s, st_r[s]); else passed++;
            total++; if (st_d[s] !== expo(13, 12, 8, 0)) $display("FAIL stall_data s=%0d got %b want %b", s, st_d[s], expo(13, 12, 8, 0)); else passed++;
        end
        for (int j = 0; j < 96; j++) begin
            total++; if (cap_d[j] !== expo(j, 12, 8, 0)) $display("FAIL stall_order j=%0d got %b want %b", j, cap_d[j], expo(j, 12, 8, 0)); else passed++;
        end
    endtask

    task automatic test_back_to_back;
        do_fill(96, 0, 0);
        do_drain(96, -1, 1);
        total++; if (din_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", din_ready); else passed++;
        total++; if (dout_valid !== 1'b0) $display("FAIL b2b_valid_drop got %b want 0", dout_valid); else passed++;
        for (int j = 0; j < 96; j++) begin
            total++; if (cap_d[j] !== expo(j, 12, 8, 0)) $display("FAIL b2b_f1 j=%0d got %b want %b", j, cap_d[j], expo(j, 12, 8, 0)); else passed++;
        end
        do_fill(96, 1, 0);
        total++; if (fill_vld != 0 || dout_valid !== 1'b1) $display("FAIL b2b_f2_phase got vld=%0d dv=%b want 0/1", fill_vld, dout_valid); else passed++;
        do_drain(96, -1, 0);
        total++; if (drain_drop != 0) $display("FAIL b2b_bubble got %0d want 0", drain_drop); else passed++;
        for (int j = 0; j < 96; j++) begin
            total++; if (cap_d[j] !== expo(j, 12, 8, 1)) $display("FAIL b2b_f2 j=%0d got %b want %b", j, cap_d[j], expo(j, 12, 8, 1)); else passed++;
        end
    endtask

    task automatic test_reset_mid;
        do_fill(40, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        total++; if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout_row !== 4'd0 || dout !== 1'b0)
            $display("FAIL rst_fill_outs got rdy=%b dv=%b row=%0d d=%b want 1/0/0/0", din_ready, dout_valid, dout_row, dout); else passed++;
        rst = 1'b0;
        @(negedge clk);
        do_fill(96, 0, 0);
        total++; if (fill_vld != 0) $display("FAIL rst_partial_kept got %0d want 0", fill_vld); else passed++;
        do_drain(30, -1, 0);
        for (int j = 0; j < 30; j++) begin
            total++; if (cap_d[j] !== expo(j, 12, 8, 0)) $display("FAIL rst_part_drain j=%0d got %b want %b", j, cap_d[j], expo(j, 12, 8, 0)); else passed++;
        end
        rst = 1'b1;
        @(negedge clk);
        total++; if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout_row !== 4'd0 || dout !== 1'b0)
            $display("FAIL rst_drain_outs got rdy=%b dv=%b row=%0d d=%b want 1/0/0/0", din_ready, dout_valid, dout_row, dout); else passed++;
`ifdef INTERLEAVER_LAST_EN
        total++; if (dout_last !== 1'b0) $display("FAIL rst_drain_last got %b want 0", dout_last); else passed++;
`endif
        rst = 1'b0;
        @(negedge clk);
        do_fill(96, 1, 0);
        total++; if (fill_vld != 0 || dout_row !== 4'd1) $display("FAIL rst_fresh_start got vld=%0d row=%0d want 0/1", fill_vld, dout_row); else passed++;
        do_drain(96, -1, 0);
        for (int j = 0; j < 96; j++) begin
            total++; if (cap_d[j] !== expo(j, 12, 8, 1) || cap_r[j] !== 4'((j % 12) + 1))
                $display("FAIL rst_fresh j=%0d got %b/%0d want %b/%0d", j, cap_d[j], cap_r[j], expo(j, 12, 8, 1), (j % 12) + 1); else passed++;
        end
    endtask

    task automatic test_corner;
        int k = 0;
        int j = 0;
        int cyc = 0;
        int maxr = 0;
        while (k < 30 && cyc < 500) begin
            c_dv  = 1'b1;
            c_din = pat(k, 0);
            if (c_din_ready) k++;
            cyc++;
            @(negedge clk);
        end
        c_dv = 1'b0;
        total++; if (k != 30 || c_dout_valid !== 1'b1) $display("FAIL corner_fill got k=%0d dv=%b want 30/1", k, c_dout_valid); else passed++;
        cyc = 0;
        while (j < 30 && cyc < 500) begin
            if (c_dout_valid) begin
                total++; if (c_dout !== expo(j, 15, 2, 0)) $display("FAIL corner_data j=%0d got %b want %b", j, c_dout, expo(j, 15, 2, 0)); else passed++;
                total++; if (c_row !== 4'((j % 15) + 1)) $display("FAIL corner_row j=%0d got %0d want %0d", j, c_row, (j % 15) + 1); else passed++;
`ifdef INTERLEAVER_LAST_EN
                total++; if (c_last !== (j == 29)) $display("FAIL corner_last j=%0d got %b want %b", j, c_last, (j == 29)); else passed++;
`endif
                if (int'(c_row) > maxr) maxr = int'(c_row);
                j++;
            end
            cyc++;
            @(negedge clk);
        end
        total++; if (maxr != 15) $display("FAIL corner_max_row got %0d want 15", maxr); else passed++;
        total++; if (j != 30 || c_dout_valid !== 1'b0 || c_din_ready !== 1'b1)
            $display("FAIL corner_end got j=%0d dv=%b rdy=%b want 30/0/1", j, c_dout_valid, c_din_ready); else passed++;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_stalls();
        test_back_to_back();
        test_reset_mid();
        test_corner();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/block_interleaver_tx.md
# block_interleaver_tx

Transmit-side row/column block interleaver, the write-order counterpart of the deinterleaver row-select path. It accepts a serial bit stream, stores one frame of ROWS×COLS bits row by row, then emits the frame column by column. Each output bit carries a 1-based row code that the receive-side 4-to-16 row decoder consumes directly. It sits between the channel encoder output and the modulator input.

## Interface
Parameters:
- ROWS, 12, rows per frame; legal range 2..15, so the row code fits 4 bits with 0 reserved.
- COLS, 8, columns per frame; legal range 2..16.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  1  serial input bit.
- din_valid  in  1  din holds a valid bit.
- din_ready  out  1  block can accept a bit this cycle.
- dout  out  1  interleaved output bit.
- dout_valid  out  1  dout and dout_row are valid.
- dout_ready  in  1  downstream accepts a bit this cycle.
- dout_row  out  4  1-based row index of the bit on dout; 0 when dout_valid=0.
- dout_last  out  1  marks the final bit of a frame; present only with INTERLEAVER_LAST_EN.

## Operation
- Storage: a ROWS×COLS bit array, written row-major: input bit k goes to row k/COLS, column k%COLS.
- FSM states:
  - FILL (reset state): din_ready=1, dout_valid=0.
  - DRAIN: din_ready=0, dout_valid=1.
- FILL
  - Each cycle with din_valid&din_ready stores din at (wr_row, wr_col).
  - wr_col increments; at COLS-1 it wraps to 0 and wr_row increments.
  - Accepting the ROWS×COLS-th bit moves the FSM to DRAIN and clears both write counters.
- DRAIN
  - Output order is column-major: for each column c = 0..COLS-1, rows r = 0..ROWS-1.
  - dout = array[rd_row][rd_col]; dout_row = rd_row+1.
  - rd_row/rd_col advance only on dout_valid&dout_ready.
  - The transfer of the last bit (row ROWS-1, column COLS-1) clears the read counters and returns the FSM to FILL.
- Backpressure: while dout_ready=0, dout, dout_row and dout_last hold stable.
- Input stall: din_valid=0 in FILL leaves state and counters unchanged.
- No overlap: the block never fills and drains at the same time, and there is no IDLE state.
- Counter widths: row counter $clog2(ROWS), column counter $clog2(COLS), each at least 1 bit. dout_row is zero-extended to 4 bits.

## Timing
- Reset values: din_ready=1, dout=0, dout_valid=0, dout_row=0, dout_last=0, state=FILL, all counters 0. Array contents are not cleared.
- Reset mid-frame, in either state, discards the partial frame. din_ready is 1 in the cycle after rst deasserts.
- The last input accept at edge N gives dout_valid=1 from cycle N+1, holding array[0][0] with dout_row=1.
- Latency from the first input bit to the first output bit is ROWS×COLS cycles at full input rate.
- Throughput: 1 bit/cycle in each phase. With no stalls, one frame takes 2×ROWS×COLS cycles.
- The last output accept at edge M gives din_ready=1 and dout_valid=0 from cycle M+1. There is no bubble beyond the phase switch.
- din_valid is ignored while din_ready=0; such bits are not stored.

## Configuration
- INTERLEAVER_LAST_EN defined:
  - dout_last exists.
  - It is high exactly when dout_valid=1, rd_row=ROWS-1 and rd_col=COLS-1.
  - It resets to 0.
- Not defined: the dout_last port is absent. All other behaviour is identical.

## Structure
- Shared package interleaver_pkg holds:
  - the default ROWS=12 and COLS=8 constants;
  - ROW_CODE_W=4;
  - the FSM state enum {FILL, DRAIN}.
  The deinterleaver side imports the same package.
- One sub-module, interleaver_addr_ctr: a generic wrap-around row/column counter with enable, synchronous clear, and a wrap flag. The block instantiates it twice, once for write and once for read.

## Test plan
- Ramp frame: drive 96 bits where din = (k%3==0) at full rate, dout_ready=1.
  - dout_valid rises the cycle after the 96th accept.
  - Output j equals input index (j%12)×8 + j/12.
  - Output 0 = input 0 (1), output 1 = input 8 (0), output 12 = input 1 (0).
  - dout_row runs 1..12 repeatedly.
- Handshake stalls: toggle din_valid randomly at 50% and hold dout_ready=0 for 5 cycles at j=13.
  - Order is unchanged from the ramp frame.
  - dout and dout_row=2 stay stable through the stall.
- Back-to-back frames: send two frames, the second inverted.
  - din_ready returns to 1 the cycle after output 95 is accepted.
  - The second frame emerges correctly with no bubble.
- Reset mid-operation: assert rst after 40 input bits, then again after 30 output bits.
  - Each time, all outputs go to reset values the next cycle.
  - A fresh frame afterwards outputs correctly.
- Last flag (INTERLEAVER_LAST_EN): dout_last is high only on output 95 with dout_row=12, and low on the other 95 bits.
- Parameter corner: ROWS=15, COLS=2. Output j equals input (j%15)×2 + j/15, and the maximum dout_row is 15.
